// File: rtl/btn_pkg.sv
// Shared definitions for push-button input stages: FSM encodings, default
// 100 MHz timing constants and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_e;

  // Defaults for a 100 MHz clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/two_ff_sync.sv
// Generic 1-bit two-flop synchroniser for asynchronous board inputs.
module two_ff_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability chain: only s2 is safe to use downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button front end: synchronise, debounce, and emit a one-cycle pulse
// per confirmed press. Optional auto-repeat while held is enabled by
// defining AUTO_REPEAT_EN.
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic pulse,
  output logic btn_level
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject nonsensical timing at elaboration
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_pulse_gen: invalid timing parameters");
  end

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q;
  logic             level_q, level_d;
  logic             btn_s2;
  logic             press_c;
  logic             rpt_fire_c;

  two_ff_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (btn_in),
    .q_o     (btn_s2)
  );

  // Debounce FSM: next state, counter and debounced level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s2) begin
          state_d = ST_DB_PRESS;
          cnt_d   = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s2) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_s2) begin
          state_d = ST_DB_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_DB_RELEASE: begin
        if (btn_s2) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= press_c | rpt_fire_c;
      level_q <= level_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W    = cnt_width(RPT_MAXV);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rep_phase_q, rep_phase_d;
  logic             rpt_hit_c;

  // Repeat timer: first interval REPEAT_DELAY, then REPEAT_PERIOD; frozen while debouncing a release
  always_comb begin
    rpt_d       = rpt_q;
    rep_phase_d = rep_phase_q;
    rpt_fire_c  = 1'b0;
    rpt_hit_c   = 1'b0;
    if (state_q == ST_IDLE || press_c) begin
      rpt_d       = '0;
      rep_phase_d = 1'b0;
    end else if (state_q == ST_HELD) begin
      rpt_hit_c = rep_phase_q ? (rpt_q == RP_LAST) : (rpt_q == RD_LAST);
      if (rpt_hit_c) begin
        rpt_d       = '0;
        rep_phase_d = 1'b1;
        rpt_fire_c  = !pulse_q;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_q       <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rpt_fire_c = 1'b0;
`endif

  assign pulse     = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: run-length reference model feeding a
// scoreboard queue, directed latency/boundary checks, then random bursts.
// Honours AUTO_REPEAT_EN in the same way as the design.
module tb_button_pulse_gen;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic btn_in  = 1'b1;
  logic pulse;
  logic btn_level;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // reference model state
  logic [1:0] m_dly;
  logic       m_s2, m_level, m_pulse, m_held;
  int         one_run, zero_run, m_acc;
  logic [1:0] exp_q[$];

  // observation bookkeeping
  int   pulse_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int   last_pulse_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  logic prev_level = 1'b0;
  int   pulse_log[$];

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_in    (btn_in),
    .pulse     (pulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model: a press/release is confirmed once the synchronised input
  // has been seen at a steady value on DB+1 consecutive edges.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_dly    = 2'b00;
        one_run  = 0;
        zero_run = 0;
        m_level  = 1'b0;
        m_acc    = 0;
        exp_q.delete();
        exp_q.push_back(2'b00);
      end else begin
        m_s2    = m_dly[1];
        m_dly   = {m_dly[0], btn_in};
        m_pulse = 1'b0;
        m_held  = m_level && (zero_run == 0);
        if (m_s2) begin
          one_run  = one_run + 1;
          zero_run = 0;
        end else begin
          zero_run = zero_run + 1;
          one_run  = 0;
        end
        if (!m_level && one_run == DB + 1) begin
          m_level = 1'b1;
          m_pulse = 1'b1;
          m_acc   = 0;
        end else if (m_level && zero_run == DB + 1) begin
          m_level = 1'b0;
        end
`ifdef AUTO_REPEAT_EN
        if (m_held) begin
          m_acc = m_acc + 1;
          if (m_acc == RD || (m_acc > RD && ((m_acc - RD) % RP) == 0))
            m_pulse = 1'b1;
        end
`endif
        exp_q.push_back({m_pulse, m_level});
      end
    end
  end

  // Monitor: every cycle the DUT presents pulse/btn_level; pop and compare
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL scoreboard_empty cyc=%0d got pulse=%b level=%b", cyc_n, pulse, btn_level);
      end else begin
        e = exp_q.pop_front();
        if ({pulse, btn_level} !== e) begin
          bad = bad + 1;
          $display("FAIL outputs cyc=%0d got pulse=%b level=%b want pulse=%b level=%b",
                   cyc_n, pulse, btn_level, e[1], e[0]);
        end
      end
      if (pulse === 1'b1) begin
        pulse_cnt      = pulse_cnt + 1;
        last_pulse_cyc = cyc_n;
        pulse_log.push_back(cyc_n);
      end
      if (btn_level === 1'b1 && !prev_level) begin
        rise_cnt = rise_cnt + 1;
        rise_cyc = cyc_n;
      end
      if (btn_level === 1'b0 && prev_level) begin
        fall_cnt = fall_cnt + 1;
        fall_cyc = cyc_n;
      end
      prev_level = (btn_level === 1'b1);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drive btn_in for one clock; returns 2 time units after the edge
  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL watchdog cyc=%0d", cyc_n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int p, r, f, c0, fp, b, n;
    int exp_off[7];
    exp_off = '{0, 20, 28, 36, 44, 52, 60};

    // reset held with button pressed
    repeat (4) @(posedge clk);
    #2;
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_level", int'(btn_level), 0);

    // press confirmed DB+3 edges after reset release
    p = pulse_cnt;
    reset_n = 1'b1;
    c0 = cyc_n;
    repeat (10) step(1'b1);
    chk("t1_pulse_count", pulse_cnt - p, 1);
    chk("t1_pulse_edge", last_pulse_cyc - c0, 7);
    chk("t1_level_edge", rise_cyc - c0, 7);

    // short release bounce while held
    p = pulse_cnt; f = fall_cnt;
    repeat (2) step(1'b0);
    repeat (10) step(1'b1);
    chk("t4_no_pulse", pulse_cnt - p, 0);
    chk("t4_no_fall", fall_cnt - f, 0);

    // release latency
    p = pulse_cnt; f = fall_cnt; c0 = cyc_n;
    repeat (12) step(1'b0);
    chk("t3_fall_count", fall_cnt - f, 1);
    chk("t3_fall_edge", fall_cyc - c0, 7);
    chk("t3_release_no_pulse", pulse_cnt - p, 0);

    // clean long press
    p = pulse_cnt; c0 = cyc_n;
    repeat (40) step(1'b1);
`ifndef AUTO_REPEAT_EN
    chk("t3_long_press_count", pulse_cnt - p, 1);
    chk("t3_long_press_edge", last_pulse_cyc - c0, 7);
`endif
    repeat (12) step(1'b0);

    // glitch shorter than the debounce window
    p = pulse_cnt; r = rise_cnt;
    repeat (3) step(1'b1);
    repeat (10) step(1'b0);
    chk("t2_glitch_no_pulse", pulse_cnt - p, 0);
    chk("t2_glitch_no_rise", rise_cnt - r, 0);

    // boundary: DB high cycles rejected, DB+1 accepted
    p = pulse_cnt;
    repeat (DB) step(1'b1);
    repeat (10) step(1'b0);
    chk("bnd_db_rejected", pulse_cnt - p, 0);
    p = pulse_cnt;
    repeat (DB + 1) step(1'b1);
    repeat (12) step(1'b0);
    chk("bnd_db1_accepted", pulse_cnt - p, 1);

    // reset during press debounce
    repeat (5) step(1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_pulse", int'(pulse), 0);
    chk("t5_async_level", int'(btn_level), 0);
    btn_in = 1'b0;
    repeat (2) step(1'b0);
    p = pulse_cnt;
    reset_n = 1'b1;
    repeat (12) step(1'b0);
    chk("t5_no_pulse_after", pulse_cnt - p, 0);

    // reset while held clears the level before the next edge
    repeat (10) step(1'b1);
    chk("t5b_held_level", int'(btn_level), 1);
    reset_n = 1'b0;
    #1;
    chk("t5b_async_level", int'(btn_level), 0);
    btn_in = 1'b0;
    repeat (2) step(1'b0);
    reset_n = 1'b1;
    repeat (12) step(1'b0);

`ifdef AUTO_REPEAT_EN
    // auto-repeat schedule while held
    p = pulse_log.size();
    n = 0;
    while (pulse_log.size() == p && n < 20) begin
      step(1'b1);
      n = n + 1;
    end
    if (pulse_log.size() == p) begin
      chk("t6_first_pulse_timeout", 0, 1);
    end else begin
      fp = pulse_log[p];
      while (cyc_n < fp + 61) step(1'b1);
      repeat (15) step(1'b0);
      chk("t6_repeat_count", pulse_log.size() - p, 7);
      for (int i = 0; i < 7; i++) begin
        if (p + i < pulse_log.size())
          chk($sformatf("t6_repeat_offset_%0d", i), pulse_log[p + i] - fp, exp_off[i]);
      end
    end
`endif

    // random bursts, including debounce-edge lengths and bounces
    repeat (300) begin
      b = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 12));
`ifdef AUTO_REPEAT_EN
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(20, 70));
`endif
      repeat (n) step(b[0]);
    end
    repeat (15) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
